// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: per-digit dead-time, 8-slice PWM
// brightness, leading-zero blanking and a per-frame snapshot of all display inputs.
module seg7_scan_driver #(
  parameter logic [15:0] DIG_CYCLES   = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] IN0,
  input  logic [3:0] IN1,
  input  logic [3:0] IN2,
  input  logic [3:0] IN3,
  input  logic [3:0] DP_IN,
  input  logic       LZ_BLANK,
  input  logic [2:0] BRIGHT,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT,
  output logic       FRAME_TICK
);

  localparam logic [15:0] SLICE_CYCLES = DIG_CYCLES >> 3;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  digit;
  logic [1:0]  digit_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] sub;
  logic [15:0] sub_nxt;
  logic [2:0]  slice;
  logic [2:0]  slice_nxt;
  logic        fresh;
  logic        fresh_nxt;
  logic        capture;

  logic [15:0] snap_val;
  logic [3:0]  snap_dp;
  logic        snap_lz;
  logic [2:0]  snap_bright;

  logic [3:0]  nib;
  logic        lead_zero;
  logic [7:0]  pat;
  logic [3:0]  sel_nxt;
  logic [7:0]  hex_nxt;

  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0:    p = 8'hC0;
      4'h1:    p = 8'hF9;
      4'h2:    p = 8'hA4;
      4'h3:    p = 8'hB0;
      4'h4:    p = 8'h99;
      4'h5:    p = 8'h92;
      4'h6:    p = 8'h82;
      4'h7:    p = 8'hF8;
      4'h8:    p = 8'h80;
      4'h9:    p = 8'h90;
      4'hA:    p = 8'h88;
      4'hB:    p = 8'h83;
      4'hC:    p = 8'hC6;
      4'hD:    p = 8'hA1;
      4'hE:    p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // The first edge after reset behaves like the frame-wrap edge so the
  // opening frame also gets a snapshot and a FRAME_TICK.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt;
    sub_nxt   = sub;
    slice_nxt = slice;
    fresh_nxt = 1'b0;
    capture   = 1'b0;
    if (fresh) begin
      state_nxt = BLANK;
      digit_nxt = 2'd0;
      cnt_nxt   = 16'd0;
      capture   = 1'b1;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_CYCLES - 16'd1) begin
            state_nxt = ON;
            cnt_nxt   = 16'd0;
            sub_nxt   = 16'd0;
            slice_nxt = 3'd0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        ON: begin
          if (cnt == DIG_CYCLES - 16'd1) begin
            state_nxt = BLANK;
            cnt_nxt   = 16'd0;
            digit_nxt = digit + 2'd1;
            capture   = (digit == 2'd3);
          end else begin
            cnt_nxt = cnt + 16'd1;
            if (sub == SLICE_CYCLES - 16'd1) begin
              sub_nxt   = 16'd0;
              slice_nxt = slice + 3'd1;
            end else begin
              sub_nxt = sub + 16'd1;
            end
          end
        end
        default: state_nxt = BLANK;
      endcase
    end
  end

  // Outputs are computed from the next state so the registered pins line up
  // with the state register. The snapshot only changes while entering BLANK,
  // so the current snapshot is valid for any ON cycle.
  always_comb begin
    nib = snap_val[{digit_nxt, 2'b00} +: 4];
    case (digit_nxt)
      2'd3:    lead_zero = (snap_val[15:12] == 4'd0);
      2'd2:    lead_zero = (snap_val[15:8] == 8'd0);
      2'd1:    lead_zero = (snap_val[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
    pat = (snap_lz && lead_zero) ? 8'hFF : decode(nib);
    if (snap_dp[digit_nxt]) begin
      pat[7] = 1'b0;
    end
    sel_nxt = 4'hF;
    hex_nxt = 8'hFF;
    if (state_nxt == ON && slice_nxt <= snap_bright) begin
      sel_nxt = ~(4'b0001 << digit_nxt);
      hex_nxt = pat;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= BLANK;
      digit          <= 2'd0;
      cnt            <= 16'd0;
      sub            <= 16'd0;
      slice          <= 3'd0;
      fresh          <= 1'b1;
      snap_val       <= 16'd0;
      snap_dp        <= 4'd0;
      snap_lz        <= 1'b0;
      snap_bright    <= 3'd0;
      SEG_SELECT_OUT <= 4'hF;
      HEX_OUT        <= 8'hFF;
      FRAME_TICK     <= 1'b0;
    end else begin
      state          <= state_nxt;
      digit          <= digit_nxt;
      cnt            <= cnt_nxt;
      sub            <= sub_nxt;
      slice          <= slice_nxt;
      fresh          <= fresh_nxt;
      SEG_SELECT_OUT <= sel_nxt;
      HEX_OUT        <= hex_nxt;
      FRAME_TICK     <= capture;
      if (capture) begin
        snap_val    <= {IN3, IN2, IN1, IN0};
        snap_dp     <= DP_IN;
        snap_lz     <= LZ_BLANK;
        snap_bright <= BRIGHT;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Frame-level scoreboard bench for seg7_scan_driver with DIG_CYCLES=16, BLANK_CYCLES=2.
module tb_seg7_scan_driver;

  localparam int NF    = 24;
  localparam int FRAME = 72;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] IN0, IN1, IN2, IN3, DP_IN;
  logic       LZ_BLANK;
  logic [2:0] BRIGHT;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;
  logic       FRAME_TICK;

  seg7_scan_driver #(.DIG_CYCLES(16'd16), .BLANK_CYCLES(16'd2)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN0(IN0), .IN1(IN1), .IN2(IN2), .IN3(IN3),
    .DP_IN(DP_IN), .LZ_BLANK(LZ_BLANK), .BRIGHT(BRIGHT),
    .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lz;
    logic [2:0]  br;
    logic        mid;
  } stim_t;

  stim_t       tab[NF];
  logic [7:0]  dec[16];
  logic [11:0] sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic apply(input int f);
    {IN3, IN2, IN1, IN0} = tab[f].val;
    DP_IN    = tab[f].dp;
    LZ_BLANK = tab[f].lz;
    BRIGHT   = tab[f].br;
  endtask

  // Expected {anode, segments} for every cycle of one frame built from tab[f].
  task automatic push_frame(input int f);
    logic [15:0] v;
    logic [3:0]  an;
    logic [7:0]  p;
    logic        blank;
    v = tab[f].val;
    for (int d = 0; d < 4; d++) begin
      blank = tab[f].lz && (d > 0) && ((v >> (4 * d)) == 16'd0);
      p = blank ? 8'hFF : dec[v[4*d +: 4]];
      if (tab[f].dp[d]) p[7] = 1'b0;
      an = 4'b0001 << d;
      an = ~an;
      for (int j = 0; j < 2; j++) sb.push_back({4'hF, 8'hFF});
      for (int j = 0; j < 16; j++) begin
        if ((j / 2) <= int'(tab[f].br)) sb.push_back({an, p});
        else sb.push_back({4'hF, 8'hFF});
      end
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (FRAME_TICK !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("tick_wait", {15'd0, FRAME_TICK}, 16'd1);
  endtask

  task automatic check_cycle(input int f, input int c);
    logic [11:0] e;
    chk($sformatf("tick_f%0d_c%0d", f, c), {15'd0, FRAME_TICK}, {15'd0, (c == 0)});
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty_f%0d_c%0d", f, c), 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("out_f%0d_c%0d", f, c), {4'd0, SEG_SELECT_OUT, HEX_OUT}, {4'd0, e});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dec = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    tab[0] = '{16'h1234, 4'b0000, 1'b0, 3'd7, 1'b0};
    for (int v = 0; v < 16; v++) begin
      tab[1 + v] = '{{12'h765, 4'(v)}, (v % 2 == 1) ? 4'b0001 : 4'b0000, 1'b0, 3'd7, 1'b0};
    end
    tab[17] = '{16'h9E3F, 4'b1010, 1'b0, 3'd0, 1'b0};
    tab[18] = '{16'h4B2C, 4'b0000, 1'b0, 3'd3, 1'b0};
    tab[19] = '{16'h0050, 4'b0000, 1'b1, 3'd7, 1'b0};
    tab[20] = '{16'h0000, 4'b0100, 1'b1, 3'd7, 1'b0};
    tab[21] = '{16'h00A5, 4'b0000, 1'b1, 3'd5, 1'b1};
    tab[22] = '{16'h00A7, 4'b0000, 1'b1, 3'd5, 1'b0};
    tab[23] = '{16'h1234, 4'b0000, 1'b0, 3'd7, 1'b0};

    RESET = 1'b1;
    apply(0);
    push_frame(0);
    repeat (3) @(negedge CLK);
    chk("rst_sel", {12'd0, SEG_SELECT_OUT}, 16'h000F);
    chk("rst_hex", {8'd0, HEX_OUT}, 16'h00FF);
    chk("rst_tick", {15'd0, FRAME_TICK}, 16'd0);
    RESET = 1'b0;
    wait_tick();

    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        check_cycle(f, c);
        if (c == 10 && tab[f].mid) IN0 = tab[f + 1].val[3:0];
        if (c == 36) begin
          apply((f + 1 < NF) ? f + 1 : f);
          push_frame((f + 1 < NF) ? f + 1 : f);
        end
        @(negedge CLK);
      end
    end

    // Repeat of the last frame; reset lands while digit 2 is lit.
    for (int c = 0; c <= 45; c++) begin
      check_cycle(NF, c);
      if (c < 45) @(negedge CLK);
    end
    #2 RESET = 1'b1;
    #1;
    chk("midrst_sel", {12'd0, SEG_SELECT_OUT}, 16'h000F);
    chk("midrst_hex", {8'd0, HEX_OUT}, 16'h00FF);
    chk("midrst_tick", {15'd0, FRAME_TICK}, 16'd0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    push_frame(NF - 1);
    wait_tick();
    for (int c = 0; c < 20; c++) begin
      check_cycle(NF + 1, c);
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
